// File: rtl/rom_adder_sweep_checker_pkg.sv
// Shared types and helpers for the ROM adder sweep checker.
package rom_adder_pkg;

    localparam int DATA_WIDTH = 4;
    localparam int NUM_PAIRS  = 2 ** (2 * DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DRAIN,
        DONE
    } sweep_state_t;

    // Reference sum for one operand pair, zero-extended so the carry is kept.
    function automatic logic [DATA_WIDTH:0] expected_sum(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/rom_adder_sweep_checker_if.sv
// Bus between the sweep checker, the adder ROM and whoever reads the status.
interface rom_adder_sweep_checker_if #(
    parameter int DATA_WIDTH = 4
) ();

    logic                    start;
    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic [DATA_WIDTH:0]     sum_in;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [2*DATA_WIDTH:0]   err_count;
    logic                    first_err_valid;
    logic [DATA_WIDTH-1:0]   first_err_a;
    logic [DATA_WIDTH-1:0]   first_err_b;
    logic [DATA_WIDTH:0]     first_err_sum;

    // Checker side: drives operands and status, receives start and the ROM sum.
    modport master (
        input  start, sum_in,
        output a, b, busy, done, pass, err_count,
               first_err_valid, first_err_a, first_err_b, first_err_sum
    );

    // ROM / host side.
    modport slave (
        output start, sum_in,
        input  a, b, busy, done, pass, err_count,
               first_err_valid, first_err_a, first_err_b, first_err_sum
    );

endinterface

// File: rtl/rom_adder_expect_pipe.sv
// Delay line carrying {valid, a, b, a+b} alongside the ROM pipeline so the
// expected sum arrives at the tap in the same cycle as the ROM's answer.
module rom_adder_expect_pipe #(
    parameter int DATA_WIDTH  = 4,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  tap_vld,
    output logic [DATA_WIDTH-1:0] tap_a,
    output logic [DATA_WIDTH-1:0] tap_b,
    output logic [DATA_WIDTH:0]   tap_sum
);
    import rom_adder_pkg::*;

    logic                  vld_p [ROM_LATENCY];
    logic [DATA_WIDTH-1:0] a_p   [ROM_LATENCY];
    logic [DATA_WIDTH-1:0] b_p   [ROM_LATENCY];
    logic [DATA_WIDTH:0]   sum_p [ROM_LATENCY];

    // Shift register; reset flushes every stage so no stale pair is ever compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
                a_p[i]   <= '0;
                b_p[i]   <= '0;
                sum_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= vld_in;
            a_p[0]   <= a_in;
            b_p[0]   <= b_in;
            sum_p[0] <= expected_sum(a_in, b_in);
            for (int i = 1; i < ROM_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                a_p[i]   <= a_p[i-1];
                b_p[i]   <= b_p[i-1];
                sum_p[i] <= sum_p[i-1];
            end
        end
    end

    assign tap_vld = vld_p[ROM_LATENCY-1];
    assign tap_a   = a_p[ROM_LATENCY-1];
    assign tap_b   = b_p[ROM_LATENCY-1];
    assign tap_sum = sum_p[ROM_LATENCY-1];

endmodule

// File: rtl/rom_adder_sweep_checker.sv
// Walks every (a, b) pair through the adder ROM, checks each returned sum
// against a + b, and reports error count, first failing pair and done/pass.
module rom_adder_sweep_checker #(
    parameter int DATA_WIDTH  = 4,
    parameter int ROM_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    rom_adder_sweep_checker_if.master bus
);
    import rom_adder_pkg::*;

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] ERR_MAX  = {1'b1, {PW{1'b0}}};
    localparam logic [PW-1:0] IDX_LAST = {PW{1'b1}};
    localparam logic [2:0]    DRAIN_LAST = 3'(ROM_LATENCY);

    // Error counter sticks at the number of pairs instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

    logic                  rst_meta;
    logic                  rst;
    sweep_state_t          state_q;
    sweep_state_t          state_d;
    logic                  clear_run;
    logic                  drive_en;
    logic [PW-1:0]         idx_q;
    logic [2:0]            drain_cnt_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  issue_vld_q;
    logic                  tap_vld;
    logic [DATA_WIDTH-1:0] tap_a;
    logic [DATA_WIDTH-1:0] tap_b;
    logic [DATA_WIDTH:0]   tap_sum;
    logic                  mismatch;
    logic [CW-1:0]         err_q;
    logic                  fe_vld_q;
    logic [DATA_WIDTH-1:0] fe_a_q;
    logic [DATA_WIDTH-1:0] fe_b_q;
    logic [DATA_WIDTH:0]   fe_sum_q;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_meta <= 1'b1;
            rst      <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst      <= rst_meta;
        end
    end

    // Sweep state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle control strobes; start is honoured only when not busy.
    always_comb begin
        state_d   = state_q;
        clear_run = 1'b0;
        drive_en  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = DRIVE;
                    clear_run = 1'b1;
                end
            end
            DRIVE: begin
                drive_en = 1'b1;
                if (idx_q == IDX_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                // One extra cycle past the ROM latency lets the last compare land first.
                if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pair index, registered operands and the issue flag that feeds the delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            issue_vld_q <= 1'b0;
        end else begin
            issue_vld_q <= drive_en;
            if (clear_run) begin
                idx_q <= '0;
            end else if (drive_en) begin
                a_q   <= idx_q[PW-1:DATA_WIDTH];
                b_q   <= idx_q[DATA_WIDTH-1:0];
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Drain cycle counter, restarted whenever the sweep is not draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  drain_cnt_q <= '0;
        else if (state_q != DRAIN) drain_cnt_q <= '0;
        else                      drain_cnt_q <= drain_cnt_q + 1'b1;
    end

    rom_adder_expect_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ROM_LATENCY (ROM_LATENCY)
    ) u_expect (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (issue_vld_q),
        .a_in    (a_q),
        .b_in    (b_q),
        .tap_vld (tap_vld),
        .tap_a   (tap_a),
        .tap_b   (tap_b),
        .tap_sum (tap_sum)
    );

    assign mismatch = tap_vld && (bus.sum_in != tap_sum);

    // Error count and first-failure capture, cleared at every accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= '0;
            fe_vld_q <= 1'b0;
            fe_a_q   <= '0;
            fe_b_q   <= '0;
            fe_sum_q <= '0;
        end else if (clear_run) begin
            err_q    <= '0;
            fe_vld_q <= 1'b0;
            fe_a_q   <= '0;
            fe_b_q   <= '0;
            fe_sum_q <= '0;
        end else if (mismatch) begin
            err_q <= sat_inc(err_q);
            if (!fe_vld_q) begin
                fe_vld_q <= 1'b1;
                fe_a_q   <= tap_a;
                fe_b_q   <= tap_b;
                fe_sum_q <= bus.sum_in;
            end
        end
    end

    assign bus.a               = a_q;
    assign bus.b               = b_q;
    assign bus.busy            = (state_q == DRIVE) || (state_q == DRAIN);
    assign bus.done            = (state_q == DONE);
    assign bus.pass            = (state_q == DONE) && (err_q == '0);
    assign bus.err_count       = err_q;
    assign bus.first_err_valid = fe_vld_q;
    assign bus.first_err_a     = fe_a_q;
    assign bus.first_err_b     = fe_b_q;
    assign bus.first_err_sum   = fe_sum_q;

endmodule

// File: doc/rom_adder_sweep_checker.md
Name: rom_adder_sweep_checker

Overview:
- Self-checking sequencer that sits directly upstream of the ROM-based truth-table adder and also consumes its output.
- Drives every operand pair (a, b) into the adder ROM, tracks the ROM pipeline latency, and compares each returned sum against a + b.
- Reports error count, first failing pair and done status.
- Used for on-FPGA ROM content self-test and by the sim bench in place of manual $display dumps.

Parameters:
- DATA_WIDTH, 4, operand width; the ROM sum is DATA_WIDTH+1 bits.
- ROM_LATENCY, 1, clock cycles from a/b change to matching sum at sum_in; legal range 1..4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a sweep
- a  output  DATA_WIDTH  operand A to adder ROM, registered
- b  output  DATA_WIDTH  operand B to adder ROM, registered
- sum_in  input  DATA_WIDTH+1  sum returned by adder ROM
- busy  output  1  high while a sweep is in progress
- done  output  1  high once a sweep completes; held until the next accepted start or reset
- pass  output  1  valid while done; high iff err_count == 0
- err_count  output  2*DATA_WIDTH+1  number of mismatching pairs, saturating at 2^(2*DATA_WIDTH)
- first_err_valid  output  1  high once at least one mismatch has been seen in the current sweep
- first_err_a  output  DATA_WIDTH  a of first mismatch
- first_err_b  output  DATA_WIDTH  b of first mismatch
- first_err_sum  output  DATA_WIDTH+1  received sum of first mismatch

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, delay line cleared. Reset mid-sweep aborts immediately and keeps no partial results.
- FSM states:
  - IDLE: start=1 -> DRIVE. Clear err_count, first_err_*, done. Load idx=0.
  - DRIVE: each cycle a<=idx[2W-1:W], b<=idx[W-1:0], idx++. This gives a outer and b inner order: (0,0),(0,1)..(0,15),(1,0)..(15,15). After driving idx = 2^(2W)-1 -> DRAIN.
  - DRAIN: hold a/b at the last values and count ROM_LATENCY cycles -> DONE.
  - DONE: done=1, busy=0. start=1 -> DRIVE with full clear, as from IDLE.
- busy = 1 in DRIVE and DRAIN.
- start while busy is ignored; the sweep is not restarted.
- Expected-value delay line: ROM_LATENCY-stage shift register of {valid, a, b, a+b}, loaded from the registered a/b.
  - Comparison happens when the tap valid=1: mismatch if sum_in != expected (full DATA_WIDTH+1 bits, zero-extended add).
  - Valid is forced 0 outside DRIVE-issued cycles, so DRAIN hold cycles never compare twice.
- Mismatch actions:
  - err_count increments, saturating.
  - If first_err_valid=0, capture a, b and sum_in from the tap and set first_err_valid.
- Timing: for N = 2^(2W), done rises exactly N + ROM_LATENCY + 1 cycles after the clk edge that samples start. That is 258 cycles for the defaults.
- a and b change only on clk edges; there is no combinational path from start to a/b.
- pass = done & (err_count == 0).

Decomposition:
- Shared package rom_adder_pkg:
  - DATA_WIDTH default.
  - Sweep FSM state enum {IDLE, DRIVE, DRAIN, DONE}.
  - Function expected_sum(a, b) returning DATA_WIDTH+1 bits.
  - Localparam NUM_PAIRS = 2**(2*DATA_WIDTH).
- One sub-module, rom_adder_expect_pipe: the ROM_LATENCY-deep {valid, a, b, expected} shift register with async reset.
- FSM, counters and error capture stay in the top.

Test Plan:
- Default params, bench instantiates the correct 1-cycle ROM adder, pulse start -> done at cycle 258, pass=1, err_count=0, first_err_valid=0.
- Faulty ROM model returns 5'h00 for a=3, b=5 -> err_count=1, first_err_a=3, first_err_b=5, first_err_sum=0, pass=0.
- ROM model with sum bit 4 stuck at 0 -> err_count=120, first_err_a=1, first_err_b=15, first_err_sum=5'h00.
- ROM_LATENCY=3 with a correct 3-cycle model -> err_count=0, done at cycle 260; a 1-cycle model with ROM_LATENCY=3 -> err_count>0.
- Pulse start again at cycle 100 mid-sweep -> ignored, done still at 258. Then start after done -> counters clear, a second sweep completes with identical results.
- Assert reset at cycle 50 during a faulty sweep -> all outputs 0 asynchronously, busy=0. A fresh start then yields the full sweep result with no carry-over.
